// File: rtl/comparator_seq.sv
// Byte-serial wide equality compare: one 74x688-style byte stage reused
// over BYTES cycles, with the accumulated result fed back as its gate.
module comparator_seq #(
    parameter int BYTES      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [8*BYTES-1:0] a,
    input  logic [8*BYTES-1:0] b,
    input  logic             ng,
    output logic             busy,
    output logic             done,
    output logic             neq
);

    localparam int W  = 8 * BYTES;
    localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [IW-1:0] FIRST = MSB_FIRST ? IW'(BYTES - 1) : '0;
    localparam logic [IW-1:0] LAST  = MSB_FIRST ? '0 : IW'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  sa;
    logic [W-1:0]  sb;
    logic [IW-1:0] idx;
    logic          acc;

    logic [7:0]    abyte;
    logic [7:0]    bbyte;
    logic          acc_n;
    logic          last;
    logic [IW-1:0] idx_n;

    // The 688 stage: gate is the running result, output is active-low equal.
    always_comb begin
        abyte = sa[{idx, 3'b000} +: 8];
        bbyte = sb[{idx, 3'b000} +: 8];
        acc_n = acc | (abyte != bbyte);
        last  = (idx == LAST);
        idx_n = MSB_FIRST ? idx - IW'(1) : idx + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            neq   <= 1'b1;
            acc   <= 1'b1;
            idx   <= FIRST;
            sa    <= '0;
            sb    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        acc <= ng;
                        idx <= FIRST;
                        if (EARLY_EXIT && ng) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            neq   <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    acc <= acc_n;
                    if (last || (EARLY_EXIT && acc_n)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        neq   <= acc_n;
                    end else begin
                        idx <= idx_n;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_seq.sv
// Self-checking bench for comparator_seq across several parameter sets,
// checked cycle by cycle against a byte-list reference model.
module tb_comparator_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ng;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic [3:0]  busy;
    logic [3:0]  done;
    logic [3:0]  neq;

    int total = 0;
    int bad   = 0;

    // per-instance parameters and last reported result
    int   NB [4] = '{4, 4, 4, 1};
    int   MS [4] = '{1, 1, 0, 1};
    int   EE [4] = '{1, 0, 1, 1};
    logic prev [4];

    always #5 clk = ~clk;

    comparator_seq #(.BYTES(4), .MSB_FIRST(1), .EARLY_EXIT(1)) u0 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ng(ng),
        .busy(busy[0]), .done(done[0]), .neq(neq[0]));
    comparator_seq #(.BYTES(4), .MSB_FIRST(1), .EARLY_EXIT(0)) u1 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ng(ng),
        .busy(busy[1]), .done(done[1]), .neq(neq[1]));
    comparator_seq #(.BYTES(4), .MSB_FIRST(0), .EARLY_EXIT(1)) u2 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ng(ng),
        .busy(busy[2]), .done(done[2]), .neq(neq[2]));
    comparator_seq #(.BYTES(1), .MSB_FIRST(1), .EARLY_EXIT(1)) u3 (
        .clk(clk), .reset(reset), .start(start), .a(a1), .b(b1), .ng(ng),
        .busy(busy[3]), .done(done[3]), .neq(neq[3]));

    // Reference: walk the byte list in order, OR in mismatches, stop early if allowed.
    function automatic void model(input logic [63:0] x, input logic [63:0] y,
                                  input logic g, input int nb, input int msb,
                                  input int ee, output int n, output logic r);
        int p;
        r = g;
        n = 0;
        if (ee != 0 && g) return;
        for (int i = 0; i < nb; i++) begin
            p = (msb != 0) ? nb - 1 - i : i;
            n++;
            if (x[8*p +: 8] != y[8*p +: 8]) r = 1'b1;
            if (ee != 0 && r) return;
        end
    endfunction

    task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic g);
        @(negedge clk);
        a = x;
        b = y;
        ng = g;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        ng = 1'b0;
        a = '0;
        b = '0;
        a1 = '0;
        b1 = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (busy[i] !== 1'b0 || done[i] !== 1'b0 || neq[i] !== 1'b1) begin
                bad++;
                $display("FAIL reset u%0d got busy=%b done=%b neq=%b exp 0 0 1",
                         i, busy[i], done[i], neq[i]);
            end
            prev[i] = 1'b1;
        end
        reset = 1'b0;
    endtask

    task automatic test_directed;
        logic [31:0] ta [3] = '{32'hDEADBEEF, 32'h12345678, 32'h00000000};
        logic [31:0] tb [3] = '{32'hDEADBEEF, 32'h12345679, 32'h00000000};
        logic        tg [3] = '{1'b0, 1'b0, 1'b1};
        int   n [3];
        logic r [3];
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 3; i++)
                model({32'h0, ta[t]}, {32'h0, tb[t]}, tg[t], NB[i], MS[i], EE[i], n[i], r[i]);
            launch(ta[t], tb[t], tg[t]);
            a = ~ta[t];
            ng = ~tg[t];
            for (int j = 0; j < 6; j++) begin
                if (j > 0) @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    total++;
                    if (busy[i] !== 1'(j < n[i]) || done[i] !== 1'(j == n[i])) begin
                        bad++;
                        $display("FAIL dir%0d_timing u%0d j=%0d got busy=%b done=%b exp %b %b",
                                 t, i, j, busy[i], done[i], 1'(j < n[i]), 1'(j == n[i]));
                    end
                    total++;
                    if (neq[i] !== ((j >= n[i]) ? r[i] : prev[i])) begin
                        bad++;
                        $display("FAIL dir%0d_neq u%0d j=%0d got=%b exp=%b",
                                 t, i, j, neq[i], (j >= n[i]) ? r[i] : prev[i]);
                    end
                end
            end
            for (int i = 0; i < 3; i++) prev[i] = r[i];
        end
    endtask

    task automatic test_random;
        logic [31:0] x;
        logic [31:0] y;
        logic        g;
        int          m;
        int   n [3];
        logic r [3];
        for (int it = 0; it < 40; it++) begin
            x = $urandom;
            y = x;
            m = $urandom_range(0, 15);
            for (int k = 0; k < 4; k++)
                if (m[k]) y[8*k +: 8] = x[8*k +: 8] ^ 8'($urandom_range(1, 255));
            g = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 3; i++)
                model({32'h0, x}, {32'h0, y}, g, NB[i], MS[i], EE[i], n[i], r[i]);
            launch(x, y, g);
            a = $urandom;
            b = $urandom;
            ng = ~g;
            for (int j = 0; j < 6; j++) begin
                if (j > 0) @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    total++;
                    if (busy[i] !== 1'(j < n[i]) || done[i] !== 1'(j == n[i])) begin
                        bad++;
                        $display("FAIL rnd_timing u%0d it=%0d j=%0d got busy=%b done=%b exp %b %b",
                                 i, it, j, busy[i], done[i], 1'(j < n[i]), 1'(j == n[i]));
                    end
                    total++;
                    if (neq[i] !== ((j >= n[i]) ? r[i] : prev[i])) begin
                        bad++;
                        $display("FAIL rnd_neq u%0d it=%0d j=%0d got=%b exp=%b",
                                 i, it, j, neq[i], (j >= n[i]) ? r[i] : prev[i]);
                    end
                end
            end
            for (int i = 0; i < 3; i++) prev[i] = r[i];
        end
    endtask

    task automatic test_capture;
        int cnt = 0;
        launch(32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
        a = 32'h0;
        ng = 1'b1;
        start = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 3) start = 1'b0;
            if (done[0] === 1'b1) cnt++;
            if (j == 4) begin
                total++;
                if (done[0] !== 1'b1 || neq[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL capture_result got done=%b neq=%b exp 1 0", done[0], neq[0]);
                end
            end
            if (j >= 5) begin
                total++;
                if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL capture_idle j=%0d got busy=%b done=%b exp 0 0",
                             j, busy[0], done[0]);
                end
            end
        end
        total++;
        if (cnt != 1) begin
            bad++;
            $display("FAIL capture_count got=%0d exp=1", cnt);
        end
        for (int i = 0; i < 3; i++) prev[i] = 1'b0;
    endtask

    task automatic test_reset_mid;
        launch(32'h12345678, 32'h12345679, 1'b0);
        total++;
        if (busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL rmid_busy got=%b exp=1", busy[0]);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (busy[0] !== 1'b0 || neq[0] !== 1'b1 || done[0] !== 1'b0) begin
            bad++;
            $display("FAIL rmid_abort got busy=%b neq=%b done=%b exp 0 1 0",
                     busy[0], neq[0], done[0]);
        end
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            total++;
            if (done[0] !== 1'b0) begin
                bad++;
                $display("FAIL rmid_nodone j=%0d got=%b exp=0", j, done[0]);
            end
        end
        for (int i = 0; i < 4; i++) prev[i] = 1'b1;
    endtask

    task automatic test_back_to_back;
        int   n;
        int   cyc;
        logic r;
        @(negedge clk);
        a1 = 8'd0;
        b1 = 8'd0;
        ng = 1'b0;
        start = 1'b1;
        model(64'd0, 64'd0, 1'b0, 1, 1, 1, n, r);
        for (int c = 0; c < 512; c++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
                if (cyc == 1) begin
                    total++;
                    if (busy[3] !== 1'(n >= 1)) begin
                        bad++;
                        $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, busy[3], 1'(n >= 1));
                    end
                end
            end while (done[3] !== 1'b1 && cyc < 4);
            total++;
            if (done[3] !== 1'b1 || cyc != n + 1) begin
                bad++;
                $display("FAIL b2b_latency c=%0d got cycles=%0d done=%b exp cycles=%0d",
                         c, cyc, done[3], n + 1);
            end
            total++;
            if (neq[3] !== r) begin
                bad++;
                $display("FAIL b2b_neq c=%0d a=%0d b=%0d ng=%b got=%b exp=%b",
                         c, a1, b1, ng, neq[3], r);
            end
            if (c < 511) begin
                a1 = 8'((c + 1) % 256);
                b1 = 8'(((c + 1) * 37 + ((c + 1) / 256) * 11) % 256);
                if ((c + 1) % 5 == 0) b1 = a1;
                ng = 1'((c + 1) / 256);
                model({56'h0, a1}, {56'h0, b1}, ng, 1, 1, 1, n, r);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_capture;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
